// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a one-cycle-latency
// instruction memory and buffers returned words with their PCs for decode.
module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0]  PC_BASE_ADDR = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  localparam int unsigned STEP  = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];

  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        occupancy;

  // The in-flight request has a slot reserved, so issuing only when
  // buffered + outstanding < depth means a landing response always fits.
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign mem_en    = !reset && !redirect_valid && fetch_en &&
                     (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign mem_addr  = fetch_pc_q - PC_BASE_ADDR;
  assign mem_rw    = 1'b1;

  assign out_valid = (count_q != '0);
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];

  assign push = !reset && !redirect_valid && inflight_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (reset) begin
      fetch_pc_d = PC_BASE_ADDR;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else if (redirect_valid) begin
      // Squash: drop the landing response and everything buffered.
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      inflight_d = 1'b0;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      inflight_d = mem_en;
      if (mem_en) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= PC_BASE_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= PC_BASE_ADDR;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= mem_data_out;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage for the MIPS pipeline. Owns the program counter, issues reads to a synchronous one-cycle-latency instruction memory, and buffers returned words with their PCs in a FIFO. Presents them to decode over a valid/ready handshake. Supports decode back-pressure, fetch gating, and branch/jump redirect with squash of in-flight and buffered instructions.

## Interface
- PC_BASE_ADDR, 32'h80020000: reset PC; memory address = PC − PC_BASE_ADDR
- ADDR_WIDTH, 32: PC and memory address width
- DATA_WIDTH, 32: instruction width; PC step = DATA_WIDTH/8
- FIFO_DEPTH, 4: buffer entries; power of two, ≥2

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fetch_en  in  1  permits issuing new memory requests
- redirect_valid  in  1  load new PC, squash everything older
- redirect_pc  in  ADDR_WIDTH  redirect target; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- mem_addr  out  ADDR_WIDTH  byte offset into instruction memory
- mem_en  out  1  request strobe
- mem_rw  out  1  tied 1 (read)
- mem_data_out  in  DATA_WIDTH  read data, valid the cycle after mem_en
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  head PC

## Operation
- State: fetch_pc, inflight (1 bit), inflight_pc, FIFO (rd_ptr, wr_ptr, count 0..FIFO_DEPTH).
- Issue: mem_en = !reset && !redirect_valid && fetch_en && (count + inflight < FIFO_DEPTH). mem_addr = fetch_pc − PC_BASE_ADDR (combinational). On issue: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH). No issue: inflight←0.
- Response: in any cycle with inflight=1 and no redirect, {mem_data_out, inflight_pc} is written at wr_ptr at the clock edge.
- Pop: out_valid && out_ready advances rd_ptr. Push and pop in the same cycle leave count unchanged. Overflow is impossible by construction of the issue rule. Pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1 in cycle t):
  - At the edge, FIFO is emptied (count←0, rd_ptr=wr_ptr).
  - The response arriving in cycle t is discarded.
  - inflight←0 and fetch_pc←aligned redirect_pc.
  - No issue in cycle t.
  - A pop handshake in cycle t still counts as accepted by decode. Redirect wins over the pop for FIFO state.
- fetch_en=0: no new issue. An in-flight response still lands. FIFO drains normally.
- Reset (cycle with reset=1): fetch_pc←PC_BASE_ADDR, inflight←0, FIFO emptied. This overrides redirect, push and pop. Mid-operation reset discards all buffered and in-flight data.
- Reset values: out_valid=0, mem_en=0, mem_rw=1. out_instr/out_pc are don't-care while out_valid=0. mem_addr=0 once fetch_pc=PC_BASE_ADDR.

## Timing
- No bypass: memory data is always registered into the FIFO before it is presented.
- Fetch-to-output latency: issue in cycle n → out_valid for that PC in cycle n+2.
- After reset deasserts (first free cycle 0): first issue in cycle 0 at PC_BASE_ADDR. out_valid=1 with out_pc=PC_BASE_ADDR in cycle 2.
- Redirect in cycle t: first issue at target in cycle t+1; out_valid with target PC in cycle t+3.
- Throughput: 1 instr/cycle sustained with out_ready=1, for FIFO_DEPTH≥3. FIFO_DEPTH=2 sustains 2 instrs per 3 cycles.
- out_valid/out_instr/out_pc are stable while out_valid=1 and out_ready=0. They depend only on registered state; there is no combinational path from out_ready.
- mem_en depends combinationally on redirect_valid, fetch_en and reset.

## Test plan
- Reset stream: memory preloaded with words at offsets 0,4,8,…; out_ready=1.
  - out_pc sequence 80020000, 80020004, 80020008… from cycle 2.
  - One per cycle, instr matches memory.
- Back-pressure: out_ready=0 from cycle 0, with FIFO_DEPTH=4.
  - Exactly 4 issues; mem_en then stays 0.
  - Head holds 80020000.
  - On release, 4 entries drain in order, then streaming resumes at 80020010 with no loss or duplicate.
- Redirect mid-stream: redirect_valid with redirect_pc=80020043 in cycle 5.
  - No mem_en in cycle 5; mem_addr=0x40 in cycle 6.
  - out_pc=80020040 in cycle 8.
  - No pre-redirect PC appears after cycle 5.
- Redirect and pop coincide while FIFO holds 3 entries.
  - count=0 next cycle; out_valid=0 until target arrives.
- Reset mid-operation with a full FIFO and a request in flight.
  - out_valid=0 the next cycle.
  - The stream restarts at 80020000 two cycles after reset drops.
- Gating and wrap: toggle fetch_en every 3 cycles for 40 cycles with random out_ready.
  - PCs strictly sequential, no gaps.
  - Pointer wrap exercised ≥5 times.
  - count never exceeds FIFO_DEPTH.
